// File: rtl/uart_pkg.sv
// Shared UART receiver definitions: FSM state encoding and framing constants.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DEFAULT_OVERSAMPLE = 16;
    localparam int unsigned MIN_DATA_BITS      = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_rx_sipo.sv
// Serial-in parallel-out shift register; bits arrive LSB first and enter at the MSB,
// so a short word ends up left-aligned and is right-aligned by the consumer.
module sipo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             s_rst_n_i,
    input  logic             enable_i,
    input  logic             data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            data_q <= '0;
        end else if (enable_i) begin
            data_q <= {data_i, data_q[WIDTH-1:1]};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver with a one-word holding register and valid/ready handoff.
// Optional parity checking is built when UART_RX_PARITY_EN is defined.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                  clk_i,
    input  logic                  s_rst_n_i,
    input  logic                  enable_i,
    input  logic                  baud_tick_i,
    input  logic                  rx_i,
    input  logic [3:0]            data_bit_num_i,
    input  logic                  stop_bit_num_i,
`ifdef UART_RX_PARITY_EN
    input  logic                  parity_en_i,
    input  logic                  parity_odd_i,
    output logic                  parity_err_o,
`endif
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  frame_err_o,
    output logic                  overrun_o
);

    localparam int unsigned TICK_W  = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned SHAMT_W = $clog2(DATA_WIDTH + 1);
    localparam logic [TICK_W-1:0] TICK_MID = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_TOP = TICK_W'(OVERSAMPLE - 1);

    logic              rx_meta_q, rx_sync_q, rx_prev_q;
    uart_state_e       state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [3:0]        nbits_q, nbits_d;
    logic              stop2_q, stop2_d;
    logic              frame_bad_q, frame_bad_d;

    logic                  sample_c;
    logic                  shift_c;
    logic                  load_c;
    logic                  load_ferr_c;
    logic [3:0]            nbits_eff_c;
    logic [SHAMT_W-1:0]    shamt_c;
    logic [DATA_WIDTH-1:0] sipo_data_c;
    logic [DATA_WIDTH-1:0] word_c;

    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q, ferr_q, ovr_q;

`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_odd_q, par_odd_d;
    logic par_acc_q, par_acc_d;
    logic par_bad_q, par_bad_d;
    logic perr_q;
`endif

    // Two-flop synchronizer plus a delayed copy for start-edge detection.
    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign sample_c    = baud_tick_i && (tick_cnt_q == TICK_MID);
    assign nbits_eff_c = (data_bit_num_i < 4'(MIN_DATA_BITS) || data_bit_num_i > 4'(DATA_WIDTH))
                         ? 4'(DATA_WIDTH) : data_bit_num_i;
    assign shamt_c     = SHAMT_W'(DATA_WIDTH) - SHAMT_W'(nbits_q);
    assign word_c      = sipo_data_c >> shamt_c;

    sipo #(
        .WIDTH (DATA_WIDTH)
    ) u_sipo (
        .clk_i     (clk_i),
        .s_rst_n_i (s_rst_n_i),
        .enable_i  (shift_c),
        .data_i    (rx_sync_q),
        .data_o    (sipo_data_c)
    );

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        nbits_d     = nbits_q;
        stop2_d     = stop2_q;
        frame_bad_d = frame_bad_q;
        shift_c     = 1'b0;
        load_c      = 1'b0;
        load_ferr_c = frame_bad_q;
`ifdef UART_RX_PARITY_EN
        par_en_d    = par_en_q;
        par_odd_d   = par_odd_q;
        par_acc_d   = par_acc_q;
        par_bad_d   = par_bad_q;
`endif

        if (state_q != ST_IDLE && baud_tick_i) begin
            tick_cnt_d = (tick_cnt_q == TICK_TOP) ? '0 : tick_cnt_q + 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d    = ST_START;
                    tick_cnt_d = '0;
                end
            end
            ST_START: begin
                if (sample_c) begin
                    if (rx_sync_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d     = ST_DATA;
                        bit_cnt_d   = 4'd0;
                        nbits_d     = nbits_eff_c;
                        stop2_d     = stop_bit_num_i;
                        frame_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        par_en_d    = parity_en_i;
                        par_odd_d   = parity_odd_i;
                        par_acc_d   = 1'b0;
                        par_bad_d   = 1'b0;
`endif
                    end
                end
            end
            ST_DATA: begin
                if (sample_c) begin
                    shift_c = 1'b1;
`ifdef UART_RX_PARITY_EN
                    par_acc_d = par_acc_q ^ rx_sync_q;
`endif
                    if (bit_cnt_q == nbits_q - 4'd1) begin
                        bit_cnt_d = 4'd0;
`ifdef UART_RX_PARITY_EN
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
`else
                        state_d   = ST_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample_c) begin
                    par_bad_d = (par_acc_q ^ rx_sync_q) != par_odd_q;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (sample_c) begin
                    if (!rx_sync_q) begin
                        frame_bad_d = 1'b1;
                    end
                    if (stop2_q && bit_cnt_q == 4'd0) begin
                        bit_cnt_d = 4'd1;
                    end else begin
                        load_c      = 1'b1;
                        load_ferr_c = frame_bad_q | !rx_sync_q;
                        state_d     = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disabling drops any partial frame; the holding register is untouched.
        if (!enable_i) begin
            state_d = ST_IDLE;
            load_c  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            state_q     <= ST_IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= 4'd0;
            nbits_q     <= 4'(DATA_WIDTH);
            stop2_q     <= 1'b0;
            frame_bad_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            par_acc_q   <= 1'b0;
            par_bad_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            nbits_q     <= nbits_d;
            stop2_q     <= stop2_d;
            frame_bad_q <= frame_bad_d;
`ifdef UART_RX_PARITY_EN
            par_en_q    <= par_en_d;
            par_odd_q   <= par_odd_d;
            par_acc_q   <= par_acc_d;
            par_bad_q   <= par_bad_d;
`endif
        end
    end

    // Holding register: a completing word wins over a same-cycle handshake.
    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else if (load_c) begin
            data_q  <= word_c;
            valid_q <= 1'b1;
            ferr_q  <= load_ferr_c;
            ovr_q   <= valid_q && !ready_i;
`ifdef UART_RX_PARITY_EN
            perr_q  <= par_bad_q;
`endif
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = perr_q;
`endif

endmodule
